// File: rtl/mse_frame_tx.sv
// mse_frame_tx: serialises each 64-bit MSE result into a fixed 10-byte frame
// (header, D7..D0, XOR checksum) on the uart_transmitter strobe interface.
// Bytes are paced by an internal counter because the transmitter has no ready.
// A depth-1 pending slot absorbs one result per frame; overwrites are reported
// through the next frame header and the sticky overrun flag.
module mse_frame_tx #(
    parameter int         BYTE_CYCLES = 8700,
    parameter logic [7:0] HDR_OK      = 8'hA5,
    parameter logic [7:0] HDR_LOSS    = 8'hA7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] mse_data,
    input  logic        mse_valid,
    output logic        com_txvalid,
    output logic [7:0]  com_txdata,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter value loaded at each pulse; the next event fires when it reaches zero.
    localparam logic [15:0] CNT_RELOAD = 16'(BYTE_CYCLES - 1);

    // XOR checksum over the eight data bytes (header excluded).
    function automatic logic [7:0] frame_chk(input logic [63:0] d);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ d[8*i +: 8];
        end
        return acc;
    endfunction

    // Byte of the frame body for index 1..9 (1 = MSB data byte, 9 = checksum).
    function automatic logic [7:0] frame_byte(input logic [63:0] d, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = d[63:56];
            4'd2:    b = d[55:48];
            4'd3:    b = d[47:40];
            4'd4:    b = d[39:32];
            4'd5:    b = d[31:24];
            4'd6:    b = d[23:16];
            4'd7:    b = d[15:8];
            4'd8:    b = d[7:0];
            4'd9:    b = frame_chk(d);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [3:0]  idx_r, idx_nxt_s;
    logic [63:0] snap_r, snap_nxt_s;
    logic [63:0] pend_data_r, pend_data_nxt_s;
    logic        pend_full_r, pend_full_nxt_s;
    logic        loss_r, loss_nxt_s;
    logic        txvalid_r, txvalid_nxt_s;
    logic [7:0]  txdata_r, txdata_nxt_s;
    logic        busy_r;

    // Next-state, pacing, pending-slot and byte-strobe logic.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        idx_nxt_s       = idx_r;
        snap_nxt_s      = snap_r;
        pend_data_nxt_s = pend_data_r;
        pend_full_nxt_s = pend_full_r;
        loss_nxt_s      = loss_r;
        txvalid_nxt_s   = 1'b0;
        txdata_nxt_s    = txdata_r;

        case (state_r)
            ST_IDLE: begin
                if (pend_full_r || mse_valid) begin
                    // Launch: the pending slot wins; a simultaneous strobe refills it.
                    if (pend_full_r) begin
                        snap_nxt_s      = pend_data_r;
                        pend_full_nxt_s = mse_valid;
                        if (mse_valid) begin
                            pend_data_nxt_s = mse_data;
                        end else begin
                            pend_data_nxt_s = pend_data_r;
                        end
                    end else begin
                        snap_nxt_s = mse_data;
                    end
                    state_nxt_s   = ST_SEND;
                    cnt_nxt_s     = CNT_RELOAD;
                    idx_nxt_s     = 4'd1;
                    txvalid_nxt_s = 1'b1;
                    txdata_nxt_s  = loss_r ? HDR_LOSS : HDR_OK;
                    loss_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_r == 16'd0) begin
                    txvalid_nxt_s = 1'b1;
                    txdata_nxt_s  = frame_byte(snap_r, idx_r);
                    cnt_nxt_s     = CNT_RELOAD;
                    if (idx_r == 4'd9) begin
                        state_nxt_s = ST_GAP;
                        idx_nxt_s   = 4'd0;
                    end else begin
                        idx_nxt_s   = idx_r + 4'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_GAP: begin
                // Lets the transmitter finish the checksum character.
                if (cnt_r == 16'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
                idx_nxt_s   = 4'd0;
            end
        endcase

        // Results arriving during a frame go to the slot; newest wins on overwrite.
        if ((state_r != ST_IDLE) && mse_valid) begin
            if (pend_full_r) begin
                loss_nxt_s = 1'b1;
            end else begin
                loss_nxt_s = loss_nxt_s;
            end
            pend_data_nxt_s = mse_data;
            pend_full_nxt_s = 1'b1;
        end else begin
            pend_full_nxt_s = pend_full_nxt_s;
        end
    end

    // State and datapath registers with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            idx_r       <= 4'd0;
            snap_r      <= 64'd0;
            pend_data_r <= 64'd0;
            pend_full_r <= 1'b0;
            loss_r      <= 1'b0;
            txvalid_r   <= 1'b0;
            txdata_r    <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            snap_r      <= snap_nxt_s;
            pend_data_r <= pend_data_nxt_s;
            pend_full_r <= pend_full_nxt_s;
            loss_r      <= loss_nxt_s;
            txvalid_r   <= txvalid_nxt_s;
            txdata_r    <= txdata_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign com_txvalid = txvalid_r;
    assign com_txdata  = txdata_r;
    assign busy        = busy_r;
    assign overrun     = loss_r;

endmodule

// File: tb/tb_mse_frame_tx.sv
// Directed bench for mse_frame_tx with BYTE_CYCLES=16: checks every cycle of
// each frame (strobe position, byte values, busy, overrun) against
// hand-computed frames, plus reset values and a mid-frame reset.
module tb_mse_frame_tx;

    localparam int BC = 16;

    logic        clk;
    logic        rstn;
    logic [63:0] mse_data;
    logic        mse_valid;
    logic        com_txvalid;
    logic [7:0]  com_txdata;
    logic        busy;
    logic        overrun;

    int n_checks;
    int n_pass;

    mse_frame_tx #(
        .BYTE_CYCLES(BC),
        .HDR_OK     (8'hA5),
        .HDR_LOSS   (8'hA7)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mse_data   (mse_data),
        .mse_valid  (mse_valid),
        .com_txvalid(com_txvalid),
        .com_txdata (com_txdata),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the header cycle of a frame. Checks all 161 cycles up to and
    // including the cycle busy falls, driving stray data every cycle and
    // strobes at the given offsets. ovr_from: first offset where overrun=1 (-1: never).
    task automatic run_frame(input string name, input logic [7:0] hdr, input logic [63:0] d,
                             input logic [7:0] chk, input int n_inj,
                             input int o0, input logic [63:0] v0,
                             input int o1, input logic [63:0] v1,
                             input int o2, input logic [63:0] v2,
                             input int ovr_from);
        logic [7:0] exp_b[10];
        exp_b[0] = hdr;
        for (int k = 1; k <= 8; k++) exp_b[k] = d[64-8*k +: 8];
        exp_b[9] = chk;
        for (int rel = 0; rel <= 10*BC; rel++) begin
            if ((rel % BC) == 0 && rel < 10*BC) begin
                check($sformatf("%s pulse@%0d", name, rel), {63'd0, com_txvalid}, 64'd1);
                check($sformatf("%s byte%0d", name, rel/BC), {56'd0, com_txdata}, {56'd0, exp_b[rel/BC]});
            end else begin
                check($sformatf("%s idle@%0d", name, rel), {63'd0, com_txvalid}, 64'd0);
            end
            check($sformatf("%s busy@%0d", name, rel), {63'd0, busy}, (rel < 10*BC) ? 64'd1 : 64'd0);
            check($sformatf("%s overrun@%0d", name, rel), {63'd0, overrun},
                  (ovr_from >= 0 && rel >= ovr_from) ? 64'd1 : 64'd0);
            if (n_inj > 0 && rel == o0) begin
                mse_valid = 1'b1; mse_data = v0;
            end else if (n_inj > 1 && rel == o1) begin
                mse_valid = 1'b1; mse_data = v1;
            end else if (n_inj > 2 && rel == o2) begin
                mse_valid = 1'b1; mse_data = v2;
            end else begin
                mse_valid = 1'b0; mse_data = {$urandom, $urandom};
            end
            step();
        end
        mse_valid = 1'b0;
    endtask

    // Single-cycle strobe from IDLE; returns in the header cycle.
    task automatic launch(input logic [63:0] d);
        mse_valid = 1'b1;
        mse_data  = d;
        step();
        mse_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        int busy_seen;
        n_checks  = 0;
        n_pass    = 0;
        rstn      = 1'b0;
        mse_valid = 1'b0;
        mse_data  = 64'd0;
        step();
        step();
        check("reset txvalid", {63'd0, com_txvalid}, 64'd0);
        check("reset txdata",  {56'd0, com_txdata},  64'd0);
        check("reset busy",    {63'd0, busy},        64'd0);
        check("reset overrun", {63'd0, overrun},     64'd0);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("idle busy", {63'd0, busy}, 64'd0);

        // Basic frame, checksum 00.
        launch(64'h0123_4567_89AB_CDEF);
        run_frame("f1", 8'hA5, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, -1);
        for (int i = 0; i < 5; i++) step();

        // Checksum FF with stray data; one pending result queued back-to-back.
        launch(64'h0000_0000_0000_00FF);
        run_frame("f2", 8'hA5, 64'h0000_0000_0000_00FF, 8'hFF, 1, 39, 64'hAAAA_AAAA_AAAA_AAAA,
                  0, 64'd0, 0, 64'd0, -1);
        run_frame("f3", 8'hA5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, -1);
        for (int i = 0; i < 3; i++) step();

        // Three results during one frame: Z survives, loss header, overrun cleared at launch.
        launch(64'h1122_3344_5566_7788);
        run_frame("f4", 8'hA5, 64'h1122_3344_5566_7788, 8'h88, 3,
                  20, 64'h0000_0000_0000_0001, 40, 64'h0000_0000_0000_0002,
                  60, 64'hFEDC_BA98_7654_3210, 41);
        run_frame("f5", 8'hA7, 64'hFEDC_BA98_7654_3210, 8'h00, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, -1);
        for (int i = 0; i < 3; i++) step();

        // Strobe exactly in the cycle busy falls.
        launch(64'h8000_0000_0000_0001);
        run_frame("f6", 8'hA5, 64'h8000_0000_0000_0001, 8'h81, 1, 10*BC, 64'h0F0F_0F0F_0F0F_0F0F,
                  0, 64'd0, 0, 64'd0, -1);
        run_frame("f7", 8'hA5, 64'h0F0F_0F0F_0F0F_0F0F, 8'h00, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, -1);
        for (int i = 0; i < 3; i++) step();

        // Reset during byte 4 with overrun set.
        launch(64'hDEAD_BEEF_CAFE_F00D);
        for (int rel = 0; rel < 66; rel++) begin
            mse_valid = (rel == 10 || rel == 20);
            mse_data  = {$urandom, $urandom};
            step();
        end
        mse_valid = 1'b0;
        check("pre-reset busy",    {63'd0, busy},    64'd1);
        check("pre-reset overrun", {63'd0, overrun}, 64'd1);
        rstn = 1'b0;
        #2;
        check("mid-reset txvalid", {63'd0, com_txvalid}, 64'd0);
        check("mid-reset txdata",  {56'd0, com_txdata},  64'd0);
        check("mid-reset busy",    {63'd0, busy},        64'd0);
        check("mid-reset overrun", {63'd0, overrun},     64'd0);
        step();
        step();
        rstn = 1'b1;
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < 12*BC; i++) begin
            step();
            if (com_txvalid) pulses++;
            if (busy) busy_seen++;
        end
        check("post-reset pulses", 64'(pulses),    64'd0);
        check("post-reset busy",   64'(busy_seen), 64'd0);
        launch(64'h0102_0408_1020_4080);
        run_frame("f8", 8'hA5, 64'h0102_0408_1020_4080, 8'hFF, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
